// File: rtl/dual_deque_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dual_deque_ctrl
// Brief   : Command sequencer driving two deques over a shared select/strobe
//           bus; optional saturating refusal counter via DQC_ERR_CNT_EN.
// Revision: 1.0
// ============================================================================
module dual_deque_ctrl #(
    parameter int WORDS     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic       cmd_sel,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       dq_select,
    output logic       dq_push,
    output logic       dq_pop,
    output logic [7:0] dq_data,
    input  logic [1:0] dq_empty,
    input  logic [1:0] dq_full,
    input  logic [7:0] dq_dout0,
    input  logic [7:0] dq_dout1
`ifdef DQC_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_XFER1 = 3'd3;
    localparam logic [2:0] S_XFER2 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_PEEK    = 3'd3;
    localparam logic [2:0] OP_REPLACE = 3'd4;
    localparam logic [2:0] OP_MOVE    = 3'd5;

    logic [2:0] r_state;
    logic [2:0] r_op;
    logic       r_sel;
    logic [7:0] r_data;
    logic [7:0] r_capture;
    logic [7:0] r_result;
    logic       r_err;

    logic       w_accept;
    logic       w_reserved;
    logic       w_empty_sel;
    logic       w_full_sel;
    logic       w_full_oth;
    logic [7:0] w_dout_sel;
    logic       w_legal;
    logic       w_refuse;

    assign w_accept    = cmd_valid && cmd_ready && (r_state == S_IDLE);
    assign w_reserved  = (cmd_op > OP_MOVE);
    assign w_empty_sel = dq_empty[r_sel];
    assign w_full_sel  = dq_full[r_sel];
    assign w_full_oth  = dq_full[~r_sel];
    assign w_dout_sel  = r_sel ? dq_dout1 : dq_dout0;

    always_comb begin
        w_legal = 1'b0;
        case (r_op)
            OP_PUSH:                     w_legal = !w_full_sel;
            OP_POP, OP_PEEK, OP_REPLACE: w_legal = !w_empty_sel;
            OP_MOVE:                     w_legal = !w_empty_sel && !w_full_oth;
            default:                     w_legal = 1'b0;
        endcase
    end

    // A refusal is decided either at accept (reserved op) or in EXEC.
    assign w_refuse = (w_accept && w_reserved) || ((r_state == S_EXEC) && !w_legal);

    // The guard only elaborates the controller for a sane configuration.
    if ((WORDS > 0) && (ERR_CNT_W > 0)) begin : g_ctrl
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state   <= S_IDLE;
                r_op      <= OP_NOP;
                r_sel     <= 1'b0;
                r_data    <= 8'h00;
                r_capture <= 8'h00;
                r_result  <= 8'h00;
                r_err     <= 1'b0;
                cmd_ready <= 1'b1;
                rsp_valid <= 1'b0;
                rsp_data  <= 8'h00;
                rsp_err   <= 1'b0;
                dq_select <= 1'b0;
                dq_push   <= 1'b0;
                dq_pop    <= 1'b0;
                dq_data   <= 8'h00;
            end else begin
                dq_push <= 1'b0;
                dq_pop  <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_op      <= cmd_op;
                            r_sel     <= cmd_sel;
                            r_data    <= cmd_data;
                            cmd_ready <= 1'b0;
                            dq_select <= cmd_sel;
                            r_result  <= 8'h00;
                            r_err     <= w_reserved;
                            if (cmd_op == OP_NOP || w_reserved) begin
                                r_state <= S_RESP;
                            end else begin
                                r_state <= S_ARM;
                            end
                        end
                    end
                    S_ARM: begin
                        r_state <= S_EXEC;
                    end
                    S_EXEC: begin
                        r_state <= S_RESP;
                        if (w_legal) begin
                            r_capture <= w_dout_sel;
                            r_result  <= (r_op == OP_PUSH) ? 8'h00 : w_dout_sel;
                            r_err     <= 1'b0;
                            case (r_op)
                                OP_PUSH: begin
                                    dq_push <= 1'b1;
                                    dq_data <= r_data;
                                end
                                OP_POP: dq_pop <= 1'b1;
                                OP_REPLACE: begin
                                    dq_push <= 1'b1;
                                    dq_pop  <= 1'b1;
                                    dq_data <= r_data;
                                end
                                OP_MOVE: begin
                                    dq_pop  <= 1'b1;
                                    r_state <= S_XFER1;
                                end
                                default: ;
                            endcase
                        end else begin
                            r_result <= 8'h00;
                            r_err    <= 1'b1;
                        end
                    end
                    S_XFER1: begin
                        dq_select <= ~r_sel;
                        r_state   <= S_XFER2;
                    end
                    S_XFER2: begin
                        dq_push <= 1'b1;
                        dq_data <= r_capture;
                        r_state <= S_RESP;
                    end
                    S_RESP: begin
                        if (!rsp_valid) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= r_result;
                            rsp_err   <= r_err;
                        end else if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            cmd_ready <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end
                endcase
            end
        end

`ifdef DQC_ERR_CNT_EN
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                err_count <= '0;
            end else if (w_refuse && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
`else
        logic w_refuse_unused;
        assign w_refuse_unused = w_refuse;
`endif
    end

endmodule
`default_nettype wire
